// File: rtl/vga_timing_gen_if.sv
// Raster signal bundle from the timing generator to the drawers.
// The generator drives it through the master modport, and consumers read it through the slave modport.
interface vga_timing_gen_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       line_start;
   logic       frame_start;

   modport master (
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start
   );

   modport slave (
      input DrawX, DrawY, blank, hs, vs, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator. Every output is registered from the next counter values.
// The hs/vs outputs also pass through a SYNC_DELAY-deep pipe, which lines them up with the drawers' registered RGB.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic             vga_clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] draw_x;
   logic [9:0] draw_y;
   logic       blank_q;
   logic       line_start_q;
   logic       frame_start_q;

   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       hs_raw_next;
   logic       vs_raw_next;

   // Stage 0 lines up with DrawX/DrawY. Stage SYNC_DELAY is what leaves the block.
   logic [SYNC_DELAY:0] hs_pipe;
   logic [SYNC_DELAY:0] vs_pipe;

   always_comb begin
      x_next = draw_x + 10'd1;
      y_next = draw_y;
      if (draw_x == H_LAST) begin
         x_next = 10'd0;
         y_next = (draw_y == V_LAST) ? 10'd0 : draw_y + 10'd1;
      end
      hs_raw_next = !((x_next >= HS_START) && (x_next < HS_END));
      vs_raw_next = !((y_next >= VS_START) && (y_next < VS_END));
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         draw_x        <= H_LAST;
         draw_y        <= V_LAST;
         blank_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hs_pipe       <= '1;
         vs_pipe       <= '1;
      end else begin
         draw_x        <= x_next;
         draw_y        <= y_next;
         blank_q       <= (x_next < H_VIS) && (y_next < V_VIS);
         line_start_q  <= (x_next == 10'd0);
         frame_start_q <= (x_next == 10'd0) && (y_next == 10'd0);
         hs_pipe[0]    <= hs_raw_next;
         vs_pipe[0]    <= vs_raw_next;
         for (int i = 1; i <= SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
         end
      end
   end

   assign vga.DrawX       = draw_x;
   assign vga.DrawY       = draw_y;
   assign vga.blank       = blank_q;
   assign vga.hs          = hs_pipe[SYNC_DELAY];
   assign vga.vs          = vs_pipe[SYNC_DELAY];
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. It runs a default-size raster and two tiny rasters with different sync delays.
// The driver pushes the expected raster state for every edge, and a monitor pops and compares it after each edge.
module tb_vga_timing_gen;

   localparam int N_CYCLES = 6000;

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen_if bus_a ();
   vga_timing_gen_if bus_b ();
   vga_timing_gen_if bus_c ();

   vga_timing_gen #(.SYNC_DELAY(0)) dut_a (
      .vga_clk (vga_clk),
      .reset   (reset),
      .vga     (bus_a)
   );

   vga_timing_gen #(
      .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .SYNC_DELAY(1)
   ) dut_b (
      .vga_clk (vga_clk),
      .reset   (reset),
      .vga     (bus_b)
   );

   vga_timing_gen #(
      .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .SYNC_DELAY(3)
   ) dut_c (
      .vga_clk (vga_clk),
      .reset   (reset),
      .vga     (bus_c)
   );

   // Packed as {DrawX, DrawY, blank, hs, vs, line_start, frame_start}
   logic [24:0] exp_a[$];
   logic [24:0] exp_b[$];
   logic [24:0] exp_c[$];

   int checks = 0;
   int errors = 0;
   bit active = 1'b1;

   // k counts non-reset edges since the last reset edge (k = 0 means the reset state).
   // Edge k shows raster position k-1; sync shows the position SYNC_DELAY edges older.
   function automatic logic [24:0] model(int k, int hv, int hf, int hsy, int hb,
                                         int vv, int vf, int vsy, int vb, int d);
      int ht, vt, p, x, y, q, sx, sy;
      logic bl, hs, vs, ls, fs;
      ht = hv + hf + hsy + hb;
      vt = vv + vf + vsy + vb;
      if (k == 0)
         return {10'(ht - 1), 10'(vt - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      p  = (k - 1) % (ht * vt);
      x  = p % ht;
      y  = p / ht;
      bl = (x < hv) && (y < vv);
      ls = (x == 0);
      fs = (p == 0);
      hs = 1'b1;
      vs = 1'b1;
      if (k - d >= 1) begin
         q  = (k - d - 1) % (ht * vt);
         sx = q % ht;
         sy = q / ht;
         hs = !((sx >= hv + hf) && (sx < hv + hf + hsy));
         vs = !((sy >= vv + vf) && (sy < vv + vf + vsy));
      end
      return {10'(x), 10'(y), bl, hs, vs, ls, fs};
   endfunction

   task automatic compare(input string name, input logic [24:0] act, input logic [24:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s t=%0t got DrawX=%0d DrawY=%0d blank,hs,vs,ls,fs=%b expected DrawX=%0d DrawY=%0d blank,hs,vs,ls,fs=%b",
                     name, $time, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
      end
   endtask

   // Monitor: one sample per edge, 1 time unit after the rising edge.
   initial begin
      forever begin
         @(posedge vga_clk);
         #1;
         if (exp_a.size() > 0) begin
            compare("dut_a", {bus_a.DrawX, bus_a.DrawY, bus_a.blank, bus_a.hs, bus_a.vs,
                              bus_a.line_start, bus_a.frame_start}, exp_a.pop_front());
            compare("dut_b", {bus_b.DrawX, bus_b.DrawY, bus_b.blank, bus_b.hs, bus_b.vs,
                              bus_b.line_start, bus_b.frame_start}, exp_b.pop_front());
            compare("dut_c", {bus_c.DrawX, bus_c.DrawY, bus_c.blank, bus_c.hs, bus_c.vs,
                              bus_c.line_start, bus_c.frame_start}, exp_c.pop_front());
         end else if (active) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow t=%0t got empty expected queue required an entry", $time);
         end
      end
   end

   // Driver: it sets reset ahead of each rising edge and pushes what that edge must produce.
   initial begin
      int k;
      int rst_left;
      bit r;
      k = 0;
      rst_left = 0;
      for (int n = 0; n < N_CYCLES; n++) begin
         if (n < 3) begin
            r = 1'b1;
         end else if (n < 2500) begin
            r = (n == 2000);
         end else if (rst_left > 0) begin
            r = 1'b1;
            rst_left--;
         end else if ($urandom_range(0, 399) == 0) begin
            r = 1'b1;
            rst_left = $urandom_range(0, 2);
         end else begin
            r = 1'b0;
         end
         reset = r;
         k = r ? 0 : k + 1;
         exp_a.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 0));
         exp_b.push_back(model(k, 4, 1, 2, 1, 3, 1, 1, 1, 1));
         exp_c.push_back(model(k, 4, 1, 2, 1, 3, 1, 1, 1, 3));
         @(negedge vga_clk);
      end
      active = 1'b0;
      @(posedge vga_clk);
      #3;
      checks++;
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d entries left required 0", exp_a.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
